// File: rtl/ps2_keyboard_decoder.sv
// PS/2 set-2 keyboard receiver and scan-code to ASCII decoder.
// Produces KeyboardInput/AdvanceCursor for the VGA text console.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FILTER_LEN     = 8,
    parameter int STROBE_CYCLES  = 4
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] KeyboardInput,
    output logic       AdvanceCursor,
    output logic       oFrameErr
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_e;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          clk_s, dat_s, bit_evt, par_ok;
    state_e        state_q, state_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [8:0]    sh_q, sh_d;
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d, sv_q, sv_d;
    logic [7:0]    scan_q, scan_d;
    logic          brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
    logic          emit;
    logic [7:0]    ecode;
    logic [9:0]    mk;
    logic [7:0]    kb_q, kb_d, pcode_q, pcode_d;
    logic          pend_q, pend_d, arm_q, arm_d, free;
    logic [SW-1:0] strb_q, strb_d;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign bit_evt = filt_q & ~filt_d;

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^sh_q;
`else
    assign par_ok = 1'b1;
`endif

    // Make-code map: {is_letter, valid, lowercase/unshifted code}
    function automatic logic [9:0] map_make(input logic [7:0] sc);
        case (sc)
            8'h1C: return {2'b11, 8'h61}; 8'h32: return {2'b11, 8'h62};
            8'h21: return {2'b11, 8'h63}; 8'h23: return {2'b11, 8'h64};
            8'h24: return {2'b11, 8'h65}; 8'h2B: return {2'b11, 8'h66};
            8'h34: return {2'b11, 8'h67}; 8'h33: return {2'b11, 8'h68};
            8'h43: return {2'b11, 8'h69}; 8'h3B: return {2'b11, 8'h6A};
            8'h42: return {2'b11, 8'h6B}; 8'h4B: return {2'b11, 8'h6C};
            8'h3A: return {2'b11, 8'h6D}; 8'h31: return {2'b11, 8'h6E};
            8'h44: return {2'b11, 8'h6F}; 8'h4D: return {2'b11, 8'h70};
            8'h15: return {2'b11, 8'h71}; 8'h2D: return {2'b11, 8'h72};
            8'h1B: return {2'b11, 8'h73}; 8'h2C: return {2'b11, 8'h74};
            8'h3C: return {2'b11, 8'h75}; 8'h2A: return {2'b11, 8'h76};
            8'h1D: return {2'b11, 8'h77}; 8'h22: return {2'b11, 8'h78};
            8'h35: return {2'b11, 8'h79}; 8'h1A: return {2'b11, 8'h7A};
            8'h45: return {2'b01, 8'h30}; 8'h16: return {2'b01, 8'h31};
            8'h1E: return {2'b01, 8'h32}; 8'h26: return {2'b01, 8'h33};
            8'h25: return {2'b01, 8'h34}; 8'h2E: return {2'b01, 8'h35};
            8'h36: return {2'b01, 8'h36}; 8'h3D: return {2'b01, 8'h37};
            8'h3E: return {2'b01, 8'h38}; 8'h46: return {2'b01, 8'h39};
            8'h29: return {2'b01, 8'h20}; 8'h4E: return {2'b01, 8'h2D};
            8'h55: return {2'b01, 8'h3D}; 8'h66: return {2'b01, 8'h7F};
            8'h76: return {2'b01, 8'h00};
            default: return 10'h000;
        endcase
    endfunction

    // PS2_CLK glitch filter: accept a new level after FILTER_LEN equal samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
            else fcnt_d = fcnt_q + 1'b1;
        end
    end

    // Frame FSM next state: start/data/parity/stop collection with idle timeout
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        scan_d  = scan_q;
        err_d   = 1'b0;
        sv_d    = 1'b0;
        to_d    = bit_evt ? '0 : to_q + 1'b1;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (bit_evt) begin
                    if (!dat_s) begin
                        state_d = SHIFT;
                        bcnt_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: if (bit_evt) begin
                sh_d = {dat_s, sh_q[8:1]};
                if (bcnt_q == 4'd8) state_d = STOP;
                else bcnt_d = bcnt_q + 1'b1;
            end
            STOP: if (bit_evt) begin
                state_d = IDLE;
                if (dat_s && par_ok) begin
                    sv_d   = 1'b1;
                    scan_d = sh_q[7:0];
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !bit_evt && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            to_d    = '0;
        end
    end

    // Decoder (shift/break/extended tracking) and emission/strobe sequencing
    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        shift_d = shift_q;
        emit    = 1'b0;
        ecode   = 8'h00;
        mk      = map_make(scan_q);
        if (sv_q) begin
            if (scan_q == 8'hF0) brk_d = 1'b1;
            else if (scan_q == 8'hE0) ext_d = 1'b1;
            else if (ext_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (scan_q == 8'h12 || scan_q == 8'h59) begin
                shift_d = !brk_q;
                brk_d   = 1'b0;
            end else if (brk_q) brk_d = 1'b0;
            else if (scan_q == 8'h5D) begin
                emit  = shift_q;
                ecode = 8'h7C;
            end else begin
                emit  = mk[8];
                ecode = (mk[9] && shift_q) ? mk[7:0] - 8'h20 : mk[7:0];
            end
        end
        // Data register loads only when the strobe path is idle; otherwise park one code
        free    = !arm_q && strb_q == '0;
        kb_d    = kb_q;
        pend_d  = pend_q;
        pcode_d = pcode_q;
        arm_d   = 1'b0;
        strb_d  = (strb_q != '0) ? strb_q - 1'b1 : '0;
        if (arm_q) strb_d = SW'(STROBE_CYCLES);
        if (emit) begin
            if (free) begin
                kb_d   = ecode;
                arm_d  = 1'b1;
                pend_d = 1'b0;
            end else begin
                pend_d  = 1'b1;
                pcode_d = ecode;
            end
        end else if (free && pend_q) begin
            kb_d   = pcode_q;
            arm_d  = 1'b1;
            pend_d = 1'b0;
        end
    end

    // All state registers
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            bcnt_q     <= '0;
            sh_q       <= '0;
            to_q       <= '0;
            err_q      <= 1'b0;
            sv_q       <= 1'b0;
            scan_q     <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            shift_q    <= 1'b0;
            kb_q       <= 8'h00;
            pcode_q    <= 8'h00;
            pend_q     <= 1'b0;
            arm_q      <= 1'b0;
            strb_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            to_q       <= to_d;
            err_q      <= err_d;
            sv_q       <= sv_d;
            scan_q     <= scan_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            shift_q    <= shift_d;
            kb_q       <= kb_d;
            pcode_q    <= pcode_d;
            pend_q     <= pend_d;
            arm_q      <= arm_d;
            strb_q     <= strb_d;
        end
    end

    assign KeyboardInput = kb_q;
    assign AdvanceCursor = strb_q != '0;
    assign oFrameErr     = err_q;
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Scoreboard bench for ps2_keyboard_decoder: a keystroke-level model pushes
// expected characters; a monitor pops them on each AdvanceCursor rise.
module tb_ps2_keyboard_decoder;
    localparam int STROBE = 4;

    logic       clk = 1'b0;
    logic       rst, ps2c, ps2d;
    logic [7:0] kb;
    logic       adv, ferr;

    always #5 clk = ~clk;

    ps2_keyboard_decoder #(.TIMEOUT_CYCLES(25000), .FILTER_LEN(8), .STROBE_CYCLES(STROBE)) dut (
        .iVGA_CLK(clk), .iRST(rst), .PS2_CLK(ps2c), .PS2_DAT(ps2d),
        .KeyboardInput(kb), .AdvanceCursor(adv), .oFrameErr(ferr)
    );

    int n_chk = 0, n_fail = 0;
    int err_cnt = 0, exp_err = 0;
    logic [7:0] expq[$];
    bit m_shift = 0, m_brk = 0, m_ext = 0;

    // Alphabetical set-2 letter codes and numeric digit codes
    logic [7:0] LSC[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] DSC[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] POOL[16] = '{8'h12, 8'h59, 8'hF0, 8'hE0, 8'h5D, 8'h1C, 8'h1A, 8'h45, 8'h46,
                             8'h29, 8'h4E, 8'h55, 8'h66, 8'h76, 8'h75, 8'h35};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Keystroke model: what a user would see on screen for each received code
    task automatic model(input logic [7:0] sc);
        if (sc == 8'hF0) m_brk = 1;
        else if (sc == 8'hE0) m_ext = 1;
        else if (m_ext) begin m_ext = 0; m_brk = 0; end
        else if (sc == 8'h12 || sc == 8'h59) begin m_shift = !m_brk; m_brk = 0; end
        else if (m_brk) m_brk = 0;
        else begin
            for (int i = 0; i < 26; i++)
                if (LSC[i] == sc) expq.push_back(8'((m_shift ? 65 : 97) + i));
            for (int i = 0; i < 10; i++)
                if (DSC[i] == sc) expq.push_back(8'(48 + i));
            case (sc)
                8'h29: expq.push_back(8'h20);
                8'h4E: expq.push_back(8'h2D);
                8'h55: expq.push_back(8'h3D);
                8'h5D: if (m_shift) expq.push_back(8'h7C);
                8'h66: expq.push_back(8'h7F);
                8'h76: expq.push_back(8'h00);
                default: ;
            endcase
        end
    endtask

    // Drive nbits of a PS/2 frame; data changes while PS2_CLK is high
    task automatic send(input logic [7:0] sc, input bit badpar, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^sc) ^ badpar, sc, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            repeat (20) @(posedge clk);
            ps2c = 1'b0;
            repeat (20) @(posedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] sc);
        model(sc);
        send(sc, 1'b0, 11);
    endtask

    // Monitor: pop on strobe rise, check data stability and strobe width
    logic       prev_adv = 0, prev_err = 0;
    logic [7:0] prev_kb = 0;
    int         width = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_adv = 0;
            prev_err = 0;
            width    = 0;
        end else begin
            if (ferr) err_cnt++;
            if (ferr && prev_err) check("err_pulse_width", 2, 1);
            if (adv && !prev_adv) begin
                check("kb_stable_before_strobe", kb, prev_kb);
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got char %0h expected none", kb);
                end else check("char", kb, expq.pop_front());
                width = 1;
            end else if (adv) width++;
            if (!adv && prev_adv) check("strobe_width", width, STROBE);
            prev_adv = adv;
            prev_err = ferr;
        end
        prev_kb = kb;
    end

    initial begin
        bit seen;
        logic [7:0] sc;
        rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_kb", kb, 0);
        check("reset_adv", adv, 0);
        check("reset_err", ferr, 0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);

        frame(8'h1C);
        foreach (POOL[i]) if (i < 0) ;
        frame(8'h12); frame(8'h1C); frame(8'hF0); frame(8'h1C);
        frame(8'hF0); frame(8'h12); frame(8'h1C);
        frame(8'h66); frame(8'h76);
        frame(8'hE0); frame(8'h75); frame(8'hE0); frame(8'hF0); frame(8'h75);
        check("no_err_clean_frames", err_cnt, exp_err);

`ifdef PS2_PARITY_CHECK_EN
        exp_err++;
`else
        model(8'h29);
`endif
        send(8'h29, 1'b1, 11);
        check("bad_parity_err", err_cnt, exp_err);

        send(8'h1C, 1'b0, 5);
        repeat (26000) @(posedge clk);
        exp_err++;
        check("timeout_err", err_cnt, exp_err);
        frame(8'h45);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) sc = 8'($urandom_range(0, 255));
            else sc = POOL[$urandom_range(0, 15)];
            frame(sc);
        end
        check("random_err", err_cnt, exp_err);

        // Reset during the strobe of "B"
        frame(8'hF0); frame(8'h29); frame(8'h12);
        model(8'h32);
        fork send(8'h32, 1'b0, 11); join_none
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (adv) seen = 1;
        end
        check("strobe_seen_before_reset", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midstrobe_reset_kb", kb, 0);
        check("midstrobe_reset_adv", adv, 0);
        check("midstrobe_reset_err", ferr, 0);
        m_shift = 0; m_brk = 0; m_ext = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait fork;
        repeat (200) @(posedge clk);
        frame(8'h1C);
        repeat (50) @(posedge clk);
        check("queue_drained", expq.size(), 0);
        check("final_err", err_cnt, exp_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
